// File: rtl/slave_axi4_lite.sv
// AXI4-Lite register slave: a small bank of word registers with independent read and write channels.
// Address and data are taken together, one transaction in flight per direction, and the responses are always OKAY.
module slave_axi4_lite #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rdata_out
);

  localparam int DATA_W = C_S_AXI_DATA_WIDTH;
  localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int NREG   = 1 << IDX_W;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  logic              awready_q, awready_d;
  logic [IDX_W-1:0]  awidx_q, awidx_d;
  logic              bvalid_q, bvalid_d;
  logic              arready_q, arready_d;
  logic [IDX_W-1:0]  aridx_q, aridx_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rdata_out_q, rdata_out_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wr_en;
  logic              rd_en;
  logic              unused_ok;

  // Protection bits and byte-offset address bits carry no meaning for word registers.
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write accept: both valids present, nothing outstanding on B, not already mid-handshake.
  always_comb begin
    awready_d = 1'b0;
    awidx_d   = awidx_q;
    if (!awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q) begin
      awready_d = 1'b1;
      awidx_d   = S_AXI_AWADDR[ADDR_W-1:2];
    end
  end

  // A master that withdraws its valids during the ready cycle gets no write.
  assign wr_en = awready_q && S_AXI_AWVALID && S_AXI_WVALID;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[awidx_q] = S_AXI_WDATA;
    end
  end

  always_comb begin
    bvalid_d = bvalid_q;
    if (wr_en) begin
      bvalid_d = 1'b1;
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    arready_d = 1'b0;
    aridx_d   = aridx_q;
    if (!arready_q && S_AXI_ARVALID && !rvalid_q) begin
      arready_d = 1'b1;
      aridx_d   = S_AXI_ARADDR[ADDR_W-1:2];
    end
  end

  assign rd_en = arready_q && S_AXI_ARVALID;

  // Reading regs_q (not regs_d) gives the pre-write value on a same-edge collision.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[aridx_q];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_comb begin
    rdata_out_d = rdata_out_q;
    if (rvalid_q && S_AXI_RREADY) begin
      rdata_out_d = rdata_q;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q   <= 1'b0;
      awidx_q     <= '0;
      bvalid_q    <= 1'b0;
      arready_q   <= 1'b0;
      aridx_q     <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rdata_out_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      awready_q   <= awready_d;
      awidx_q     <= awidx_d;
      bvalid_q    <= bvalid_d;
      arready_q   <= arready_d;
      aridx_q     <= aridx_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rdata_out_q <= rdata_out_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign rdata_out     = rdata_out_q;

endmodule

// File: tb/tb_slave_axi4_lite.sv
// Bench for slave_axi4_lite: directed scenarios plus randomized traffic, with responses checked
// by a scoreboard monitor against a word-array model of the register bank.
module tb_slave_axi4_lite;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk;
  logic          S_AXI_ARESETN;
  logic [AW-1:0] S_AXI_AWADDR;
  logic [2:0]    S_AXI_AWPROT;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [DW-1:0] S_AXI_WDATA;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [AW-1:0] S_AXI_ARADDR;
  logic [2:0]    S_AXI_ARPROT;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [DW-1:0] S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;
  logic [DW-1:0] rdata_out;

  slave_axi4_lite #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .rdata_out(rdata_out)
  );

  logic [DW-1:0] model [4];
  logic [DW-1:0] exp_r [$];
  logic [1:0]    exp_b [$];
  int            total = 0;
  int            bad = 0;
  int            aw_cnt = 0;
  int            ar_cnt = 0;
  logic          pend_rdo = 1'b0;
  logic [DW-1:0] last_r = '0;
  logic          rand_ready = 1'b0;
  logic          bready_force = 1'b1;
  logic          rready_force = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ready driver: forced values or random back-pressure, applied just after each rising edge.
  initial begin
    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      S_AXI_BREADY = rand_ready ? 1'($urandom_range(0, 1)) : bready_force;
      S_AXI_RREADY = rand_ready ? 1'($urandom_range(0, 1)) : rready_force;
    end
  end

  // Scoreboard monitor: pops the expected response whenever a handshake is presented.
  always @(negedge clk) begin
    if (!S_AXI_ARESETN) begin
      exp_r.delete();
      exp_b.delete();
      pend_rdo = 1'b0;
    end else begin
      if (S_AXI_AWREADY) aw_cnt++;
      if (S_AXI_ARREADY) ar_cnt++;
      if (pend_rdo) begin
        chk("rdata_out", rdata_out, last_r);
        pend_rdo = 1'b0;
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (exp_r.size() == 0) begin
          total++;
          bad++;
          $display("FAIL r_unexpected: got 0x%0h want no response", S_AXI_RDATA);
        end else begin
          last_r = exp_r.pop_front();
          chk("rdata", S_AXI_RDATA, last_r);
          chk("rresp", 32'(S_AXI_RRESP), 32'd0);
          pend_rdo = 1'b1;
        end
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (exp_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_unexpected: got resp %0d want no response", S_AXI_BRESP);
        end else begin
          chk("bresp", 32'(S_AXI_BRESP), 32'(exp_b.pop_front()));
        end
      end
    end
  end

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input bit lat);
    int n = 0;
    exp_b.push_back(2'b00);
    model[a[3:2]] = d;
    S_AXI_AWADDR  = a;
    S_AXI_WDATA   = d;
    S_AXI_AWPROT  = 3'($urandom);
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    do begin
      step();
      n++;
    end while (!S_AXI_AWREADY && n < 50);
    if (!S_AXI_AWREADY) begin
      total++;
      bad++;
      $display("FAIL aw_timeout: got no AWREADY in %0d cycles want accept", n);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      return;
    end
    chk("wready_with_awready", 32'(S_AXI_WREADY), 32'd1);
    if (lat) chk("aw_latency", n, 32'd1);
    step();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    chk("awready_pulse", 32'(S_AXI_AWREADY), 32'd0);
    if (lat) chk("bvalid_rise", 32'(S_AXI_BVALID), 32'd1);
    step();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] e, input bit lat);
    int n = 0;
    exp_r.push_back(e);
    S_AXI_ARADDR  = a;
    S_AXI_ARPROT  = 3'($urandom);
    S_AXI_ARVALID = 1'b1;
    do begin
      step();
      n++;
    end while (!S_AXI_ARREADY && n < 50);
    if (!S_AXI_ARREADY) begin
      total++;
      bad++;
      $display("FAIL ar_timeout: got no ARREADY in %0d cycles want accept", n);
      S_AXI_ARVALID = 1'b0;
      return;
    end
    if (lat) chk("ar_latency", n, 32'd1);
    step();
    S_AXI_ARVALID = 1'b0;
    chk("arready_pulse", 32'(S_AXI_ARREADY), 32'd0);
    if (lat) chk("rvalid_rise", 32'(S_AXI_RVALID), 32'd1);
    step();
  endtask

  initial begin
    logic [31:0] old;
    logic [3:0]  ra;
    int          aw_before;
    int          ar_before;
    S_AXI_ARESETN = 1'b0;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARPROT  = '0;
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_wready", 32'(S_AXI_WREADY), 32'd0);
    chk("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    chk("rst_rdata_out", rdata_out, 32'd0);
    S_AXI_ARESETN = 1'b1;
    step();

    do_read(4'h4, 32'h0, 1'b1);
    do_write(4'h8, 32'hDEADBEEF, 1'b1);
    do_read(4'h8, 32'hDEADBEEF, 1'b1);
    chk("rdata_out_after_read", rdata_out, 32'hDEADBEEF);

    do_write(4'h0, 32'h11, 1'b1);
    do_write(4'h4, 32'h22, 1'b1);
    do_write(4'h8, 32'h33, 1'b1);
    do_write(4'hC, 32'h44, 1'b1);
    do_read(4'hD, 32'h44, 1'b1);

    // Read and write of the same register launched together: read sees the old value.
    old = model[1];
    fork
      do_write(4'h4, 32'h5555AAAA, 1'b1);
      do_read(4'h4, old, 1'b1);
    join
    do_read(4'h4, 32'h5555AAAA, 1'b1);

    // Stalled write response blocks a second write.
    bready_force = 1'b0;
    do_write(4'h8, 32'hA5A5A5A5, 1'b1);
    repeat (5) step();
    chk("bvalid_held", 32'(S_AXI_BVALID), 32'd1);
    aw_before = aw_cnt;
    fork
      do_write(4'hC, 32'h0BADF00D, 1'b0);
    join_none
    repeat (4) step();
    chk("aw_blocked_by_bvalid", aw_cnt, aw_before);
    chk("bvalid_still_held", 32'(S_AXI_BVALID), 32'd1);
    bready_force = 1'b1;
    wait fork;

    // Stalled read data blocks a second read address.
    rready_force = 1'b0;
    do_read(4'h8, 32'hA5A5A5A5, 1'b1);
    ar_before = ar_cnt;
    fork
      do_read(4'h0, model[0], 1'b0);
    join_none
    repeat (4) step();
    chk("rvalid_held", 32'(S_AXI_RVALID), 32'd1);
    chk("rdata_held", S_AXI_RDATA, 32'hA5A5A5A5);
    chk("ar_blocked_by_rvalid", ar_cnt, ar_before);
    rready_force = 1'b1;
    wait fork;
    do_read(4'hC, 32'h0BADF00D, 1'b1);

    // Randomized traffic under random back-pressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      ra = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(ra, $urandom, 1'b0);
      else do_read(ra, model[ra[3:2]], 1'b0);
    end
    rand_ready = 1'b0;
    repeat (10) step();
    chk("rand_r_drained", exp_r.size(), 32'd0);
    chk("rand_b_drained", exp_b.size(), 32'd0);

    // Reset while read data is waiting.
    do_write(4'h8, 32'hCAFEF00D, 1'b1);
    do_read(4'h8, 32'hCAFEF00D, 1'b1);
    rready_force = 1'b0;
    do_read(4'h8, 32'hCAFEF00D, 1'b1);
    #1;
    S_AXI_ARESETN = 1'b0;
    #1;
    chk("rst_mid_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("rst_mid_rdata", S_AXI_RDATA, 32'd0);
    chk("rst_mid_rdata_out", rdata_out, 32'd0);
    for (int i = 0; i < 4; i++) model[i] = '0;
    step();
    S_AXI_ARESETN = 1'b1;
    rready_force = 1'b1;
    step();
    do_read(4'h8, 32'h0, 1'b1);

    // Reset between accept and write edge aborts the write.
    S_AXI_AWADDR  = 4'h4;
    S_AXI_WDATA   = 32'h12345678;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    @(posedge clk);
    #2;
    S_AXI_ARESETN = 1'b0;
    #1;
    chk("rst_abort_awready", 32'(S_AXI_AWREADY), 32'd0);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    step();
    S_AXI_ARESETN = 1'b1;
    step();
    do_read(4'h4, 32'h0, 1'b1);
    do_write(4'h0, 32'h600DCAFE, 1'b1);
    do_read(4'h0, 32'h600DCAFE, 1'b1);

    repeat (4) step();
    chk("final_r_drained", exp_r.size(), 32'd0);
    chk("final_b_drained", exp_b.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slave_axi4_lite.md
SLAVE_AXI4_LITE -- requirements
Module: slave_axi4_lite

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: data bus width in bits.
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4: byte address width; the defaults give 4 word registers.
REQ-003 The block SHALL have a single clock, S_AXI_ACLK, input, 1 bit; all logic is rising-edge.
REQ-004 The block SHALL have reset S_AXI_ARESETN, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have the write-address ports: S_AXI_AWADDR in ADDR_W, S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-006 The block SHALL have the write-data ports: S_AXI_WDATA in DATA_W, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-007 The block SHALL have the write-response ports: S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-008 The block SHALL have the read-address ports: S_AXI_ARADDR in ADDR_W, S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1.
REQ-009 The block SHALL have the read-data ports: S_AXI_RDATA out DATA_W, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-010 The block SHALL have output rdata_out, DATA_W bits: copy of the last completed read data.

Function
REQ-011 The block SHALL contain 2^(ADDR_W-2) registers of DATA_W bits, selected by address bits [ADDR_W-1:2]; bits [1:0] and the *PROT inputs are ignored.
REQ-012 AWREADY SHALL pulse high for exactly one cycle, on the cycle after AWVALID=1, WVALID=1, AWREADY=0 and BVALID=0 are all sampled; the AWADDR sampled on that same edge is latched.
REQ-013 WREADY SHALL pulse high for one cycle coincident with AWREADY, under the same condition; address and data are accepted only together.
REQ-014 On the edge where AWREADY=WREADY=1, the addressed register SHALL be loaded with the full WDATA word; there are no byte strobes.
REQ-015 BVALID SHALL rise on the cycle after the write edge, hold with BRESP=00 until sampled with BREADY=1, then clear on that edge.
REQ-016 No new write SHALL be accepted while BVALID=1.
REQ-017 ARREADY SHALL pulse high for one cycle, on the cycle after ARVALID=1, ARREADY=0 and RVALID=0 are sampled; the ARADDR sampled on that same edge is latched.
REQ-018 On the ARREADY-high edge, RDATA SHALL be loaded with the addressed register and RVALID set, with RRESP=00.
REQ-019 RDATA and RVALID SHALL hold until sampled with RREADY=1; RVALID then clears and RDATA holds its value.
REQ-020 No new read address SHALL be accepted while RVALID=1.
REQ-021 rdata_out SHALL load RDATA on each edge where RVALID=RREADY=1, and hold otherwise.
REQ-022 The read and write channels SHALL be independent and may complete in the same cycles.
REQ-023 If a read captures a register on the same edge that register is written, the read SHALL return the pre-write value.
REQ-024 Read latency SHALL be 2 cycles from ARVALID to RVALID; write latency SHALL be 2 cycles from AW/WVALID to BVALID.
REQ-025 A valid input dropped before its ready SHALL NOT be accepted.

Reset
REQ-026 Asserting S_AXI_ARESETN=0 SHALL immediately clear AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA, rdata_out, all registers and latched addresses.
REQ-027 Reset mid-transaction SHALL abort the transaction; an unaccepted write leaves the registers at 0.
REQ-028 After reset release, the first transaction SHALL be accepted on the normal timing.

Verification
REQ-029 Scenario: reset, then read address 0x4 -> ARREADY one-cycle pulse, RVALID next, RDATA=0x00000000, RRESP=00.
REQ-030 Scenario: write 0xDEADBEEF to 0x8 with BREADY=1 -> AWREADY and WREADY pulse together, BVALID for 1 cycle, BRESP=00; read 0x8 -> 0xDEADBEEF and rdata_out=0xDEADBEEF.
REQ-031 Scenario: write 0x11, 0x22, 0x33, 0x44 to 0x0/0x4/0x8/0xC, then read 0xD -> 0x00000044 (low bits ignored).
REQ-032 Scenario: hold BREADY=0 for 5 cycles -> BVALID stays 1 and a second AW/W is not accepted until BREADY=1.
REQ-033 Scenario: hold RREADY=0 -> RVALID and RDATA stable, ARREADY stays 0 while a new ARVALID is pending.
REQ-034 Scenario: assert reset while RVALID=1 -> RVALID, RDATA and rdata_out are 0 immediately, and a subsequent read of 0x8 returns 0.
